// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared op/state types, constants and op decode helpers for muldiv_unit
package muldiv_pkg;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_e;

    localparam logic [31:0] DIV_ZERO_Q = 32'hFFFF_FFFF;
    localparam logic [31:0] INT_MIN    = 32'h8000_0000;

    function automatic logic is_div(op_e op);
        return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
    endfunction

    function automatic logic is_rem(op_e op);
        return op inside {OP_REM, OP_REMU};
    endfunction

    function automatic logic a_signed(op_e op);
        return op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
    endfunction

    function automatic logic b_signed(op_e op);
        return op inside {OP_MULH, OP_DIV, OP_REM};
    endfunction

    // Divide by zero and signed INT_MIN / -1 have fixed architectural results.
    function automatic logic is_special(op_e op, logic [31:0] a, logic [31:0] b);
        return is_div(op) &&
               ((b == 32'd0) || (b_signed(op) && (a == INT_MIN) && (b == DIV_ZERO_Q)));
    endfunction

    function automatic logic [31:0] special_result(op_e op, logic [31:0] a, logic [31:0] b);
        if (b == 32'd0) begin
            return is_rem(op) ? a : DIV_ZERO_Q;
        end
        return is_rem(op) ? 32'd0 : INT_MIN;
    endfunction

endpackage

// File: rtl/muldiv_signfix.sv
// rtl/muldiv_signfix.sv - conditional two's-complement negate, used for operand magnitude and result sign fix
module muldiv_signfix #(
    parameter int W = 32
) (
    input  logic [W-1:0] value,
    input  logic         negate,
    output logic [W-1:0] out
);

    assign out = negate ? ((~value) + W'(1)) : value;

endmodule

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - RV32M iterative multiply/divide unit, one bit per cycle.
// MULDIV_FAST_SPECIAL_EN: divide-by-zero and signed overflow complete without the CALC phase.
module muldiv_unit
    import muldiv_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [2:0]  funct3,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    input  logic [4:0]  rd_in,
    input  logic        kill,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic [4:0]  rd_out
);

    state_e      state, state_next;
    op_e         fn, fn_in;
    logic [4:0]  cnt, rd_q;
    logic [31:0] a_q, b_q, opnd, acc_hi, acc_lo, result_q;
    logic [31:0] mag_a, mag_b, acc_hi_n, acc_lo_n, quo_fix, rem_fix, result_final;
    logic [63:0] prod_fix;
    logic [32:0] mul_sum, div_shift, div_diff;
    logic        sign_a, sign_b, accept, fast, last;

    assign fn_in  = op_e'(funct3);
    assign accept = (state == S_IDLE) && start;
    assign last   = (cnt == 5'd31);

`ifdef MULDIV_FAST_SPECIAL_EN
    assign fast = is_special(fn_in, op_a, op_b);
`else
    assign fast = 1'b0;
`endif

    muldiv_signfix #(.W(32)) u_abs_a (
        .value  (op_a),
        .negate (a_signed(fn_in) && op_a[31]),
        .out    (mag_a)
    );

    muldiv_signfix #(.W(32)) u_abs_b (
        .value  (op_b),
        .negate (b_signed(fn_in) && op_b[31]),
        .out    (mag_b)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (start) state_next = fast ? S_DONE : S_CALC;
            S_CALC: begin
                if (kill)      state_next = S_IDLE;
                else if (last) state_next = S_DONE;
            end
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (state == S_CALC);
        done = (state == S_DONE);
    end

    // acc_hi/acc_lo hold {product hi, multiplier/product lo} or {remainder, dividend/quotient}.
    always_comb begin
        mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : 33'd0);
        div_shift = {acc_hi, acc_lo[31]};
        div_diff  = div_shift - {1'b0, opnd};
        if (is_div(fn)) begin
            acc_hi_n = div_diff[32] ? div_shift[31:0] : div_diff[31:0];
            acc_lo_n = {acc_lo[30:0], ~div_diff[32]};
        end else begin
            acc_hi_n = mul_sum[32:1];
            acc_lo_n = {mul_sum[0], acc_lo[31:1]};
        end
    end

    assign sign_a = a_signed(fn) && a_q[31];
    assign sign_b = b_signed(fn) && b_q[31];

    muldiv_signfix #(.W(64)) u_fix_prod (
        .value  ({acc_hi_n, acc_lo_n}),
        .negate (sign_a ^ sign_b),
        .out    (prod_fix)
    );

    muldiv_signfix #(.W(32)) u_fix_quo (
        .value  (acc_lo_n),
        .negate (sign_a ^ sign_b),
        .out    (quo_fix)
    );

    // Remainder takes the dividend's sign.
    muldiv_signfix #(.W(32)) u_fix_rem (
        .value  (acc_hi_n),
        .negate (sign_a),
        .out    (rem_fix)
    );

    always_comb begin
        result_final = rem_fix;
        case (fn)
            OP_MUL:                       result_final = prod_fix[31:0];
            OP_MULH, OP_MULHSU, OP_MULHU: result_final = prod_fix[63:32];
            OP_DIV, OP_DIVU:              result_final = quo_fix;
            default:                      result_final = rem_fix;
        endcase
        if (is_special(fn, a_q, b_q)) begin
            result_final = special_result(fn, a_q, b_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fn       <= OP_MUL;
            a_q      <= '0;
            b_q      <= '0;
            rd_q     <= '0;
            cnt      <= '0;
            opnd     <= '0;
            acc_hi   <= '0;
            acc_lo   <= '0;
            result_q <= '0;
        end else if (accept) begin
            fn     <= fn_in;
            a_q    <= op_a;
            b_q    <= op_b;
            rd_q   <= rd_in;
            cnt    <= '0;
            opnd   <= is_div(fn_in) ? mag_b : mag_a;
            acc_hi <= '0;
            acc_lo <= is_div(fn_in) ? mag_a : mag_b;
            if (fast) begin
                result_q <= special_result(fn_in, op_a, op_b);
            end
        end else if ((state == S_CALC) && !kill) begin
            acc_hi <= acc_hi_n;
            acc_lo <= acc_lo_n;
            cnt    <= cnt + 5'd1;
            if (last) begin
                result_q <= result_final;
            end
        end
    end

    assign result = result_q;
    assign rd_out = rd_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - self-checking bench for muldiv_unit (vector table, random ops vs arithmetic model, kill/reset sequences)
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst_n, start, kill, busy, done;
    logic [2:0]  funct3;
    logic [31:0] op_a, op_b, result;
    logic [4:0]  rd_in, rd_out;

    int n_cmp    = 0;
    int n_fail   = 0;
    int done_cnt = 0;

    always #5 clk = ~clk;

    muldiv_unit dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .funct3 (funct3),
        .op_a   (op_a),
        .op_b   (op_b),
        .rd_in  (rd_in),
        .kill   (kill),
        .busy   (busy),
        .done   (done),
        .result (result),
        .rd_out (rd_out)
    );

    always @(negedge clk) if (done) done_cnt <= done_cnt + 1;

    typedef struct {
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [14];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_model(logic [2:0] f, logic [31:0] a, logic [31:0] b);
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        longint ua = longint'({32'd0, a});
        longint ub = longint'({32'd0, b});
        longint p;
        logic   ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (f)
            3'd0: p = ua * ub;
            3'd1: p = sa * sb;
            3'd2: p = sa * ub;
            3'd3: p = ua * ub;
            3'd4: begin if (b == 0) return 32'hFFFF_FFFF; if (ovf) return 32'h8000_0000; p = sa / sb; end
            3'd5: begin if (b == 0) return 32'hFFFF_FFFF; p = ua / ub; end
            3'd6: begin if (b == 0) return a; if (ovf) return 32'd0; p = sa % sb; end
            default: begin if (b == 0) return a; p = ua % ub; end
        endcase
        if (f inside {3'd1, 3'd2, 3'd3}) return p[63:32];
        return p[31:0];
    endfunction

    function automatic int exp_lat(logic [2:0] f, logic [31:0] a, logic [31:0] b);
`ifdef MULDIV_FAST_SPECIAL_EN
        if (f[2] && ((b == 0) || ((f == 3'd4 || f == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)))
            return 1;
`endif
        return 33;
    endfunction

    // Called at a negedge; returns at the negedge of the done cycle (lat=0 on timeout).
    task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input logic with_kill,
                          output logic [31:0] res, output logic [4:0] rdo,
                          output int lat, output int busy_n);
        start = 1'b1; funct3 = f; op_a = a; op_b = b; rd_in = rd; kill = with_kill;
        lat = 0; busy_n = 0; res = '0; rdo = '0;
        @(posedge clk);
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            kill = 1'b0;
            if (done) begin
                start = 1'b0;
                lat = c; res = result; rdo = rd_out;
                break;
            end
            if (busy) busy_n++;
            start  = 1'($urandom_range(0, 1));
            funct3 = 3'($urandom);
            op_a   = $urandom;
            op_b   = $urandom;
            rd_in  = 5'($urandom);
        end
        start = 1'b0;
    endtask

    logic [31:0] res, ra, rb;
    logic [4:0]  rdo, rdv;
    logic [2:0]  rf;
    int          lat, busy_n, d0, el;

    initial begin
        vecs[0]  = '{3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB};
        vecs[1]  = '{3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE};
        vecs[2]  = '{3'd1, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'h0000_0000};
        vecs[3]  = '{3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD};
        vecs[4]  = '{3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF};
        vecs[5]  = '{3'd5, 32'd100,        32'd7,         32'd14};
        vecs[6]  = '{3'd4, 32'd5,          32'd0,         32'hFFFF_FFFF};
        vecs[7]  = '{3'd6, 32'd5,          32'd0,         32'd5};
        vecs[8]  = '{3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000};
        vecs[9]  = '{3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0};
        vecs[10] = '{3'd2, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF};
        vecs[11] = '{3'd4, 32'hFFFF_FFFB,  32'd0,         32'hFFFF_FFFF};
        vecs[12] = '{3'd7, 32'd7,          32'd0,         32'd7};
        vecs[13] = '{3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000};

        rst_n = 1'b0; start = 1'b0; kill = 1'b0; funct3 = '0;
        op_a = '0; op_b = '0; rd_in = '0;
        repeat (3) @(negedge clk);
        chk("reset busy", busy, 0);
        chk("reset done", done, 0);
        chk("reset result", result, 0);
        chk("reset rd_out", rd_out, 0);

        // First start coincides with reset release.
        rst_n = 1'b1;
        for (int i = 0; i < 14; i++) begin
            el = exp_lat(vecs[i].f, vecs[i].a, vecs[i].b);
            run_op(vecs[i].f, vecs[i].a, vecs[i].b, 5'(i + 1), 1'b0, res, rdo, lat, busy_n);
            chk($sformatf("vec%0d result", i), res, vecs[i].exp);
            chk($sformatf("vec%0d rd_out", i), rdo, 5'(i + 1));
            chk($sformatf("vec%0d latency", i), lat, el);
            chk($sformatf("vec%0d busy cycles", i), busy_n, (el == 1) ? 0 : 32);
            @(negedge clk);
            chk($sformatf("vec%0d held result", i), result, vecs[i].exp);
        end

        for (int i = 0; i < 60; i++) begin
            rf = 3'($urandom);
            ra = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: rb = 32'hFFFF_FFFF;
                2: rb = 32'($urandom_range(1, 20));
                default: rb = $urandom;
            endcase
            rdv = 5'($urandom);
            run_op(rf, ra, rb, rdv, 1'b0, res, rdo, lat, busy_n);
            chk($sformatf("rand%0d f=%0d a=%0h b=%0h result", i, rf, ra, rb), res, ref_model(rf, ra, rb));
            chk($sformatf("rand%0d latency", i), lat, exp_lat(rf, ra, rb));
            chk($sformatf("rand%0d rd_out", i), rdo, rdv);
            @(negedge clk);
        end

        // kill in CALC, then a fresh op two cycles later
        d0 = done_cnt;
        start = 1'b1; funct3 = 3'd5; op_a = 32'h1234_5678; op_b = 32'd3; rd_in = 5'd9;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        chk("kill pre busy", busy, 1);
        kill = 1'b1;
        @(negedge clk);
        kill = 1'b0;
        chk("kill busy", busy, 0);
        chk("kill done", done, 0);
        @(negedge clk);
        run_op(3'd7, 32'd10, 32'd3, 5'd3, 1'b0, res, rdo, lat, busy_n);
        chk("after kill result", res, 1);
        chk("after kill latency", lat, 33);
        @(negedge clk);
        chk("kill done pulses", done_cnt - d0, 1);

        // kill together with start in IDLE: start wins
        run_op(3'd0, 32'd6, 32'd7, 5'd4, 1'b1, res, rdo, lat, busy_n);
        chk("kill+start result", res, 42);
        chk("kill+start latency", lat, 33);
        @(negedge clk);

        // reset mid-operation
        start = 1'b1; funct3 = 3'd3; op_a = $urandom; op_b = $urandom; rd_in = 5'd17;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midreset busy", busy, 0);
        chk("midreset done", done, 0);
        chk("midreset result", result, 0);
        chk("midreset rd_out", rd_out, 0);
        d0 = done_cnt;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (36) @(negedge clk);
        chk("midreset no done", done_cnt - d0, 0);
        run_op(3'd5, 32'd100, 32'd7, 5'd21, 1'b0, res, rdo, lat, busy_n);
        chk("post reset result", res, 14);
        chk("post reset rd_out", rdo, 21);
        chk("post reset latency", lat, 33);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 Parameters SHALL be none; data width is fixed at 32 bits.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  reset; asynchronous, active-low.
REQ-004 start  input  1  request, sampled on the clk edge while in IDLE.
REQ-005 funct3  input  3  RV32M op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-006 op_a  input  32  rs1 operand, taken from register-file read port 1.
REQ-007 op_b  input  32  rs2 operand, taken from register-file read port 2.
REQ-008 rd_in  input  5  destination register index.
REQ-009 kill  input  1  synchronous abort of an in-flight operation.
REQ-010 busy  output  1  high while an operation is in flight; the core stalls on busy.
REQ-011 done  output  1  one-cycle pulse; result and rd_out are valid only in that cycle.
REQ-012 result  output  32  write-back data for the register-file write port.
REQ-013 rd_out  output  5  write-back index, latched from rd_in at start.

Function
REQ-014 The FSM SHALL have the states IDLE, CALC and DONE, and SHALL be in IDLE after reset.
REQ-015 When start=1 in IDLE, the block SHALL latch funct3, op_a, op_b and rd_in, clear the iteration counter and enter CALC on the same edge; operand changes after that edge have no effect.
REQ-016 The block SHALL ignore start in CALC and DONE.
REQ-017 CALC SHALL run exactly 32 cycles, one bit per cycle:
- multiply: shift-add producing a 64-bit product of operand magnitudes;
- divide: restoring division producing a 32-bit quotient and remainder of operand magnitudes.
REQ-018 The block SHALL enter DONE after the 32nd CALC cycle and return to IDLE on the next edge.
- start sampled at edge N -> busy=1 from N+1 through N+32, done=1 only in cycle N+33.
- A new start is accepted no earlier than the N+34 edge.
REQ-019 Signedness SHALL follow funct3:
- MULH, DIV and REM treat both operands as signed.
- MULHSU treats op_a as signed and op_b as unsigned.
- The sign fix (two's-complement negate) SHALL be applied when entering DONE.
REQ-020 Result selection: MUL = product[31:0]; MULH/MULHSU/MULHU = product[63:32]; DIV/DIVU = quotient; REM/REMU = remainder.
REQ-021 The remainder sign SHALL equal the dividend sign; the quotient SHALL truncate toward zero.
REQ-022 Divide by zero SHALL give quotient 0xFFFFFFFF and remainder = op_a, for both signed and unsigned.
REQ-023 Signed overflow (0x80000000 / 0xFFFFFFFF) SHALL give quotient 0x80000000 and remainder 0.
REQ-024 kill=1 in CALC or DONE SHALL return the FSM to IDLE on the next edge with no done pulse; kill=1 in IDLE SHALL have no effect.
REQ-025 When kill and start are both 1 in IDLE, the block SHALL accept start.
REQ-026 busy SHALL be 1 in CALC only; done SHALL be 1 in DONE only; result and rd_out SHALL be held stable from DONE until the next accepted start.

Reset
REQ-027 rst_n=0 SHALL asynchronously force IDLE, busy=0, done=0, result=0, rd_out=0, counter=0 and clear all operand and accumulator registers.
REQ-028 Reset asserted mid-operation SHALL abort the operation with no done pulse.
REQ-029 The first start SHALL be accepted on the first rising edge after rst_n deasserts.

Configuration
REQ-030 The macro MULDIV_FAST_SPECIAL_EN SHALL control early completion of special division cases.
- Defined: divide by zero and signed overflow skip CALC, going IDLE -> DONE, so done=1 in cycle N+1 and busy stays 0.
- Undefined: those cases take the full 32-cycle CALC and produce the same REQ-022/023 values.

Structure
REQ-031 Package muldiv_pkg SHALL hold the funct3 op enum, the FSM state enum and the constants DIV_ZERO_Q=32'hFFFFFFFF and INT_MIN=32'h80000000.
REQ-032 Sub-module muldiv_signfix (combinational magnitude/negate helper, used for operand abs and result sign fix) SHALL be the only sub-module.

Verification
REQ-033 MUL with 7 x -3 (0xFFFFFFFD) -> done at N+33, result 0xFFFFFFEB.
REQ-034 MULHU with 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULH on the same operands -> 0x00000000.
REQ-035 DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14.
REQ-036 DIV 5/0 -> 0xFFFFFFFF and REM 5/0 -> 5; DIV 0x80000000/-1 -> 0x80000000.
- Done at N+1 with MULDIV_FAST_SPECIAL_EN defined, at N+33 without it.
REQ-037 kill at N+10, then start at N+12 with REMU 10/3 -> no done for the first op; done at N+45, result 1.
REQ-038 rst_n low at N+5 -> busy=0 and done=0 immediately, no done pulse follows; start after release completes normally.
